// File: rtl/mem_blk_copy_if.sv
// ============================================================================
// Module      : mem_blk_copy_if
// Description : Command handshake and memory-port bundle for the block-copy
//               engine. The master modport is the engine; the slave modport is
//               the command issuer and memory side. With MEM_BLK_COPY_FILL_EN
//               defined the bundle also carries cmd_fill/cmd_pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_blk_copy_if #(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH  = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_src_addr;
   logic [ADDR_WIDTH-1:0] cmd_dst_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef MEM_BLK_COPY_FILL_EN
   logic                  cmd_fill;
   logic [DATA_WIDTH-1:0] cmd_pattern;
`endif
   logic                  busy;
   logic                  done;
   logic [LEN_WIDTH-1:0]  xfer_cnt;
   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic [STRB_WIDTH-1:0] mem_strb;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   modport master (
`ifdef MEM_BLK_COPY_FILL_EN
      input  cmd_fill,
      input  cmd_pattern,
`endif
      input  cmd_valid,
      output cmd_ready,
      input  cmd_src_addr,
      input  cmd_dst_addr,
      input  cmd_len,
      output busy,
      output done,
      output xfer_cnt,
      output mem_wr_en,
      output mem_rd_en,
      output mem_addr,
      output mem_wr_data,
      output mem_strb,
      input  mem_rd_data
   );

   modport slave (
`ifdef MEM_BLK_COPY_FILL_EN
      output cmd_fill,
      output cmd_pattern,
`endif
      output cmd_valid,
      input  cmd_ready,
      output cmd_src_addr,
      output cmd_dst_addr,
      output cmd_len,
      input  busy,
      input  done,
      input  xfer_cnt,
      input  mem_wr_en,
      input  mem_rd_en,
      input  mem_addr,
      input  mem_wr_data,
      input  mem_strb,
      output mem_rd_data
   );
endinterface

`default_nettype wire

// File: rtl/mem_blk_copy.sv
// ============================================================================
// Module      : mem_blk_copy
// Description : Memory block-copy initiator. Accepts one command at a time,
//               then runs read / capture / write per word with ascending,
//               wrapping addresses and pulses done on completion.
//               Optional macro MEM_BLK_COPY_FILL_EN adds a fill mode that
//               writes a latched pattern once per cycle without reading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_blk_copy #(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH  = 16
) (
   input  wire logic      mem_clk,
   input  wire logic      mem_rst_n,
   mem_blk_copy_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] strb_q, strb_d;
   logic                  fill_now;
`ifdef MEM_BLK_COPY_FILL_EN
   logic                  fill_q, fill_d;
   logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
`endif

   // State register; reset aborts any transfer in flight immediately
   always_ff @(posedge mem_clk) begin
      if (!mem_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and registered memory-port outputs
   always_ff @(posedge mem_clk) begin
      if (!mem_rst_n) begin
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
`ifdef MEM_BLK_COPY_FILL_EN
         fill_q    <= 1'b0;
         pattern_q <= '0;
`endif
      end else begin
         src_q     <= src_d;
         dst_q     <= dst_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
`ifdef MEM_BLK_COPY_FILL_EN
         fill_q    <= fill_d;
         pattern_q <= pattern_d;
`endif
      end
   end

   // Next state, then memory outputs decoded from the state being entered
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
`ifdef MEM_BLK_COPY_FILL_EN
      fill_d    = fill_q;
      pattern_d = pattern_q;
      if (state_q == S_IDLE && bus.cmd_valid) begin
         fill_d    = bus.cmd_fill;
         pattern_d = bus.cmd_pattern;
      end
      fill_now  = fill_d;
`else
      fill_now  = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               src_d = bus.cmd_src_addr;
               dst_d = bus.cmd_dst_addr;
               rem_d = bus.cmd_len;
               cnt_d = '0;
               if (bus.cmd_len == '0) begin
                  state_d = S_DONE;
               end else if (fill_now) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD:  state_d = S_CAP;
         S_CAP: begin
            data_d  = bus.mem_rd_data;
            state_d = S_WR;
         end
         S_WR: begin
            cnt_d = cnt_q + 1'b1;
            src_d = src_q + 1'b1;
            dst_d = dst_q + 1'b1;
            rem_d = rem_q - 1'b1;
            // rem_q still counts the word being written now
            if (rem_q == LEN_WIDTH'(1)) begin
               state_d = S_DONE;
            end else if (fill_now) begin
               state_d = S_WR;
            end else begin
               state_d = S_RD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      rd_en_d = (state_d == S_RD);
      wr_en_d = (state_d == S_WR);
      addr_d  = '0;
      wdata_d = '0;
      strb_d  = '0;
      if (rd_en_d) begin
         addr_d = src_d;
      end else if (wr_en_d) begin
         addr_d = dst_d;
         strb_d = '1;
`ifdef MEM_BLK_COPY_FILL_EN
         wdata_d = fill_d ? pattern_d : data_d;
`else
         wdata_d = data_d;
`endif
      end
   end

   assign bus.cmd_ready   = (state_q == S_IDLE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.xfer_cnt    = cnt_q;
   assign bus.mem_rd_en   = rd_en_q;
   assign bus.mem_wr_en   = wr_en_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wr_data = wdata_q;
   assign bus.mem_strb    = strb_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_blk_copy.sv
// ============================================================================
// Module      : tb_mem_blk_copy
// Description : Scoreboard bench for mem_blk_copy. Stimulus computes the
//               expected memory traffic from a plain copy loop over a model
//               memory and queues it; a negedge monitor checks every access
//               and done pulse against those queues.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_blk_copy;
   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int SW    = DW / 8;
   localparam int LW    = 8;
   localparam int DEPTH = 1 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_blk_copy_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .LEN_WIDTH(LW)) bus ();

   mem_blk_copy #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .LEN_WIDTH(LW)) dut (
      .mem_clk   (clk),
      .mem_rst_n (rst_n),
      .bus       (bus)
   );

   int n_cmp  = 0;
   int n_err  = 0;
   int cyc    = 0;
   int n_done = 0;

   logic [DW-1:0] mem  [DEPTH];
   logic [DW-1:0] refm [DEPTH];
   logic [DW-1:0] rd_data_r = '0;
   assign bus.mem_rd_data = rd_data_r;

   logic [AW-1:0] rdq  [$];
   logic [AW-1:0] wraq [$];
   logic [DW-1:0] wrdq [$];
   int            dcq  [$];
   int            dnq  [$];

   // Memory model: reads return data the cycle after mem_rd_en is sampled
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_wr_en === 1'b1) mem[bus.mem_addr] = bus.mem_wr_data;
      if (bus.mem_rd_en === 1'b1) rd_data_r <= mem[bus.mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unexpected event expected none", name);
   endtask

   // Monitor: pop and compare on every memory access and done pulse
   always @(negedge clk) begin
      if (bus.mem_rd_en === 1'b1 || bus.mem_wr_en === 1'b1)
         chk("rd_wr_exclusive", 64'(bus.mem_rd_en & bus.mem_wr_en), 64'd0);
      if (bus.mem_rd_en === 1'b1) begin
         if (rdq.size() == 0) fail_now("unexpected_read");
         else begin
            chk("rd_addr", 64'(bus.mem_addr), 64'(rdq.pop_front()));
            chk("rd_strb", 64'(bus.mem_strb), 64'd0);
         end
      end
      if (bus.mem_wr_en === 1'b1) begin
         if (wraq.size() == 0) fail_now("unexpected_write");
         else begin
            chk("wr_addr", 64'(bus.mem_addr), 64'(wraq.pop_front()));
            chk("wr_data", 64'(bus.mem_wr_data), 64'(wrdq.pop_front()));
            chk("wr_strb", 64'(bus.mem_strb), 64'({SW{1'b1}}));
         end
      end
      if (bus.done === 1'b1) begin
         if (dcq.size() == 0) fail_now("unexpected_done");
         else begin
            chk("done_cycle", 64'(cyc), 64'(dcq.pop_front()));
            chk("done_xfer_cnt", 64'(bus.xfer_cnt), 64'(dnq.pop_front()));
         end
         n_done++;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd0);
      chk({tag, "_xfer_cnt"}, 64'(bus.xfer_cnt), 64'd0);
      chk({tag, "_wr_en"}, 64'(bus.mem_wr_en), 64'd0);
      chk({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
      chk({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
      chk({tag, "_wr_data"}, 64'(bus.mem_wr_data), 64'd0);
      chk({tag, "_strb"}, 64'(bus.mem_strb), 64'd0);
   endtask

   task automatic scramble_cmd();
      bus.cmd_src_addr = AW'($urandom);
      bus.cmd_dst_addr = AW'($urandom);
      bus.cmd_len      = LW'($urandom);
`ifdef MEM_BLK_COPY_FILL_EN
      bus.cmd_fill     = 1'($urandom);
      bus.cmd_pattern  = $urandom;
`endif
   endtask

   // Model the command as a sequential word loop, queue the expected
   // traffic, then hand the command to the DUT. nmodel limits how many
   // words are expected (aborted runs); wait_done expects completion.
   task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                        input bit fill, input logic [DW-1:0] pat,
                        input int nmodel, input bit wait_done);
      int acc0;
      int lat;
      int target;
      int k;
      logic [AW-1:0] a_s;
      logic [AW-1:0] a_d;
      for (int i = 0; i < nmodel; i++) begin
         a_s = s + AW'(i);
         a_d = d + AW'(i);
         if (fill) refm[a_d] = pat;
         else begin
            rdq.push_back(a_s);
            refm[a_d] = refm[a_s];
         end
         wraq.push_back(a_d);
         wrdq.push_back(refm[a_d]);
      end
      @(negedge clk);
      bus.cmd_valid    = 1'b1;
      bus.cmd_src_addr = s;
      bus.cmd_dst_addr = d;
      bus.cmd_len      = LW'(n);
`ifdef MEM_BLK_COPY_FILL_EN
      bus.cmd_fill     = fill;
      bus.cmd_pattern  = pat;
`endif
      chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
      acc0   = cyc;
      target = n_done + 1;
      if (n == 0) lat = 1;
      else if (fill) lat = n + 1;
      else lat = 3 * n + 1;
      if (wait_done) begin
         dcq.push_back(acc0 + lat);
         dnq.push_back(n);
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      scramble_cmd();
      if (wait_done) begin
         k = 0;
         while (n_done < target && k < 1000) begin
            @(posedge clk);
            k++;
         end
         if (n_done < target) fail_now("done_timeout");
      end
   endtask

   initial begin
      logic [AW-1:0] rs;
      logic [AW-1:0] rd;
      int            rn;
      bit            rf;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]  = $urandom;
         refm[i] = mem[i];
      end
      bus.cmd_valid = 1'b0;
      scramble_cmd();

      // Reset held two cycles
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Directed copy of four preloaded words
      for (int i = 0; i < 4; i++) begin
         mem[2 + i]  = 32'hA0 + 32'(i);
         refm[2 + i] = 32'hA0 + 32'(i);
      end
      issue(4'h2, 4'h8, 4, 1'b0, '0, 4, 1'b1);

      // Zero-length command
      issue(4'h5, 4'h9, 0, 1'b0, '0, 0, 1'b1);

      // Source and destination wrap around the address space
      issue(4'hF, 4'h7, 2, 1'b0, '0, 2, 1'b1);

      // Overlapping ascending copy propagates data
      issue(4'h3, 4'h4, 3, 1'b0, '0, 3, 1'b1);

      // Ignored command while busy, then reset during the second write
      issue(4'h1, 4'hA, 4, 1'b0, '0, 2, 1'b0);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      scramble_cmd();
      chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
      chk("busy_running", 64'(bus.busy), 64'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("abort");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

`ifdef MEM_BLK_COPY_FILL_EN
      // Pattern fill of three words
      issue(4'h8, 4'h8, 3, 1'b1, 32'hDEADBEEF, 3, 1'b1);
`endif

      // Random commands
      for (int t = 0; t < 25; t++) begin
         rs = AW'($urandom);
         rd = AW'($urandom);
         rn = $urandom_range(0, 6);
         rf = 1'b0;
`ifdef MEM_BLK_COPY_FILL_EN
         rf = 1'($urandom);
`endif
         issue(rs, rd, rn, rf, $urandom, rn, 1'b1);
      end

      @(negedge clk);
      chk("rd_queue_empty", 64'(rdq.size()), 64'd0);
      chk("wr_queue_empty", 64'(wraq.size()), 64'd0);
      chk("done_queue_empty", 64'(dcq.size()), 64'd0);
      for (int i = 0; i < DEPTH; i++) chk("final_mem", 64'(mem[i]), 64'(refm[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
